// File: rtl/forwarding_hazard_unit_if.sv
// Decode-side hazard/forwarding bundle between the ID stage and the
// forwarding/hazard unit.
interface forwarding_hazard_unit_if #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
);
    logic [REG_BITS-1:0] ID_Rs;
    logic [REG_BITS-1:0] ID_Rt;
    logic                ID_UsesRt;
    logic [REG_BITS-1:0] ID_WriteReg;
    logic                ID_RegWrite;
    logic                ID_MemRead;
    logic                Flush;
    logic [1:0]          ForwardA;
    logic [1:0]          ForwardB;
    logic                Stall;
    logic [CNT_BITS-1:0] StallCount;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_WriteReg, ID_RegWrite, ID_MemRead, Flush,
        input  ForwardA, ForwardB, Stall, StallCount
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_WriteReg, ID_RegWrite, ID_MemRead, Flush,
        output ForwardA, ForwardB, Stall, StallCount
    );
endinterface

// File: rtl/forwarding_hazard_unit.sv
// EX-stage operand forwarding selectors and load-use stall detection, driven
// from a private shadow copy of the EX/MEM/WB register-write fields.
module forwarding_hazard_unit #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    forwarding_hazard_unit_if.slave  bus
);

    typedef struct packed {
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        logic [REG_BITS-1:0] wr;
        logic                rw;
        logic                mr;
    } ex_t;

    typedef struct packed {
        logic [REG_BITS-1:0] wr;
        logic                rw;
    } wr_t;

    ex_t                 r_ex;
    wr_t                 r_mem;
    wr_t                 r_wb;
    logic [CNT_BITS-1:0] r_cnt;
    logic                w_stall;

    // The load flag is not carried past EX: nothing downstream consumes it.
    function automatic logic [1:0] fwd_sel(input logic [REG_BITS-1:0] src,
                                           input wr_t mem, input wr_t wb);
        if (mem.rw && mem.wr != '0 && mem.wr == src) return 2'b10;
        if (wb.rw  && wb.wr  != '0 && wb.wr  == src) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        w_stall = 1'b0;
        if (r_ex.mr && r_ex.wr != '0 &&
            (r_ex.wr == bus.ID_Rs || (bus.ID_UsesRt && r_ex.wr == bus.ID_Rt)))
            w_stall = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            r_mem <= '{wr: r_ex.wr, rw: r_ex.rw};
            r_wb  <= r_mem;
            if (w_stall || bus.Flush)
                r_ex <= '0;
            else
                r_ex <= '{rs: bus.ID_Rs, rt: bus.ID_Rt, wr: bus.ID_WriteReg,
                          rw: bus.ID_RegWrite, mr: bus.ID_MemRead};
        end
    end

    // A flushed load-use is not a real stall cycle, so it is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_cnt <= '0;
        else if (w_stall && !bus.Flush && r_cnt != '1)
            r_cnt <= r_cnt + CNT_BITS'(1);
    end

    assign bus.ForwardA   = fwd_sel(r_ex.rs, r_mem, r_wb);
    assign bus.ForwardB   = fwd_sel(r_ex.rt, r_mem, r_wb);
    assign bus.Stall      = w_stall;
    assign bus.StallCount = r_cnt;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench for forwarding_hazard_unit: each stimulus row pushes the
// outputs expected during that cycle; the owning test pops and compares them.
module tb_forwarding_hazard_unit;
    localparam int RB = 5;
    localparam int CB = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    forwarding_hazard_unit_if #(.REG_BITS(RB), .CNT_BITS(CB)) bus ();
    forwarding_hazard_unit #(.REG_BITS(RB), .CNT_BITS(CB)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct packed {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          st;
        logic [CB-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // row: rs rt usesRt wr regWrite memRead flush | fa fb stall cnt
    task automatic drive(input int r[11]);
        exp_t e;
        @(negedge clk);
        bus.ID_Rs       = RB'(r[0]);
        bus.ID_Rt       = RB'(r[1]);
        bus.ID_UsesRt   = r[2][0];
        bus.ID_WriteReg = RB'(r[3]);
        bus.ID_RegWrite = r[4][0];
        bus.ID_MemRead  = r[5][0];
        bus.Flush       = r[6][0];
        e.fa = 2'(r[7]); e.fb = 2'(r[8]); e.st = r[9][0]; e.cnt = CB'(r[10]);
        sb.push_back(e);
    endtask

    function automatic exp_t observe();
        return '{fa: bus.ForwardA, fb: bus.ForwardB, st: bus.Stall, cnt: bus.StallCount};
    endfunction

    task automatic test_reset();
        exp_t e, o;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.ID_Rs       = RB'($urandom);
            bus.ID_Rt       = RB'($urandom);
            bus.ID_UsesRt   = 1'($urandom);
            bus.ID_WriteReg = RB'($urandom);
            bus.ID_RegWrite = 1'($urandom);
            bus.ID_MemRead  = 1'($urandom);
            bus.Flush       = 1'($urandom);
            sb.push_back('0);
            #2;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset row %0d: got fa=%b fb=%b st=%b cnt=%0d want fa=%b fb=%b st=%b cnt=%0d",
                         i, o.fa, o.fb, o.st, o.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
        @(negedge clk);
        bus.ID_Rs = '0; bus.ID_Rt = '0; bus.ID_UsesRt = 1'b0; bus.ID_WriteReg = '0;
        bus.ID_RegWrite = 1'b0; bus.ID_MemRead = 1'b0; bus.Flush = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_ex_fwd();
        int t[5][11];
        int r[11];
        exp_t e, o;
        t = '{'{0,0,0,3,1,0,0, 0,0,0,0},
              '{3,4,1,6,1,0,0, 0,0,0,0},
              '{0,0,0,0,0,0,0, 2,0,0,0},
              '{0,0,0,0,0,0,0, 0,0,0,0},
              '{0,0,0,0,0,0,0, 0,0,0,0}};
        for (int i = 0; i < 5; i++) begin
            r = t[i]; drive(r); #2;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ex_fwd row %0d: got fa=%b fb=%b st=%b cnt=%0d want fa=%b fb=%b st=%b cnt=%0d",
                         i, o.fa, o.fb, o.st, o.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_wb_fwd();
        int t[12][11];
        int r[11];
        exp_t e, o;
        t = '{'{0,0,0,5,1,0,0, 0,0,0,0},
              '{0,0,0,0,0,0,0, 0,0,0,0},
              '{2,5,1,7,1,0,0, 0,0,0,0},
              '{0,0,0,0,0,0,0, 0,1,0,0},
              '{0,0,0,0,0,0,0, 0,0,0,0},
              '{0,0,0,0,0,0,0, 0,0,0,0},
              '{0,0,0,5,1,0,0, 0,0,0,0},
              '{0,0,0,5,1,0,0, 0,0,0,0},
              '{2,5,1,7,1,0,0, 0,0,0,0},
              '{0,0,0,0,0,0,0, 0,2,0,0},
              '{0,0,0,0,0,0,0, 0,0,0,0},
              '{0,0,0,0,0,0,0, 0,0,0,0}};
        for (int i = 0; i < 12; i++) begin
            r = t[i]; drive(r); #2;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL wb_fwd row %0d: got fa=%b fb=%b st=%b cnt=%0d want fa=%b fb=%b st=%b cnt=%0d",
                         i, o.fa, o.fb, o.st, o.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_load_use();
        int t[6][11];
        int r[11];
        exp_t e, o;
        // the dependent add is re-presented while the front end is held
        t = '{'{0,0,0,8,1,1,0, 0,0,0,0},
              '{8,9,1,10,1,0,0, 0,0,1,0},
              '{8,9,1,10,1,0,0, 0,0,0,1},
              '{0,0,0,0,0,0,0, 1,0,0,1},
              '{0,0,0,0,0,0,0, 0,0,0,1},
              '{0,0,0,0,0,0,0, 0,0,0,1}};
        for (int i = 0; i < 6; i++) begin
            r = t[i]; drive(r); #2;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL load_use row %0d: got fa=%b fb=%b st=%b cnt=%0d want fa=%b fb=%b st=%b cnt=%0d",
                         i, o.fa, o.fb, o.st, o.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_no_stall();
        int t[9][11];
        int r[11];
        exp_t e, o;
        t = '{'{0,0,0,0,1,1,0, 0,0,0,1},
              '{0,3,1,4,1,0,0, 0,0,0,1},
              '{0,0,0,0,0,0,0, 0,0,0,1},
              '{0,0,0,0,0,0,0, 0,0,0,1},
              '{0,0,0,8,1,1,0, 0,0,0,1},
              '{1,8,0,9,1,0,0, 0,0,0,1},
              '{0,0,0,0,0,0,0, 0,2,0,1},
              '{0,0,0,0,0,0,0, 0,0,0,1},
              '{0,0,0,0,0,0,0, 0,0,0,1}};
        for (int i = 0; i < 9; i++) begin
            r = t[i]; drive(r); #2;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL no_stall row %0d: got fa=%b fb=%b st=%b cnt=%0d want fa=%b fb=%b st=%b cnt=%0d",
                         i, o.fa, o.fb, o.st, o.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_flush();
        int t[8][11];
        int r[11];
        exp_t e, o;
        t = '{'{0,0,0,8,1,1,0, 0,0,0,1},
              '{8,0,0,9,1,0,1, 0,0,1,1},
              '{0,0,0,0,0,0,0, 0,0,0,1},
              '{0,0,0,0,0,0,0, 0,0,0,1},
              '{0,0,0,3,1,0,1, 0,0,0,1},
              '{3,0,0,0,0,0,0, 0,0,0,1},
              '{0,0,0,0,0,0,0, 0,0,0,1},
              '{0,0,0,0,0,0,0, 0,0,0,1}};
        for (int i = 0; i < 8; i++) begin
            r = t[i]; drive(r); #2;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL flush row %0d: got fa=%b fb=%b st=%b cnt=%0d want fa=%b fb=%b st=%b cnt=%0d",
                         i, o.fa, o.fb, o.st, o.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t[4][11];
        int r[11];
        exp_t e, o;
        t = '{'{0,0,0,5,1,0,0, 0,0,0,1},
              '{0,0,0,8,1,1,0, 0,0,0,1},
              '{8,5,1,9,1,0,0, 0,0,1,1},
              '{0,0,0,0,0,0,0, 0,0,0,0}};
        for (int i = 0; i < 3; i++) begin
            r = t[i]; drive(r); #2;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid row %0d: got fa=%b fb=%b st=%b cnt=%0d want fa=%b fb=%b st=%b cnt=%0d",
                         i, o.fa, o.fb, o.st, o.cnt, e.fa, e.fb, e.st, e.cnt);
            end
        end
        // pull reset between clock edges, with the hazard still on the inputs
        #1 reset = 1'b0;
        sb.push_back('0);
        #1;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_mid async: got fa=%b fb=%b st=%b cnt=%0d want fa=%b fb=%b st=%b cnt=%0d",
                     o.fa, o.fb, o.st, o.cnt, e.fa, e.fb, e.st, e.cnt);
        end
        r = t[3]; drive(r); reset = 1'b1; #2;
        e = sb.pop_front(); o = observe(); checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_mid release: got fa=%b fb=%b st=%b cnt=%0d want fa=%b fb=%b st=%b cnt=%0d",
                     o.fa, o.fb, o.st, o.cnt, e.fa, e.fb, e.st, e.cnt);
        end
    endtask

    task automatic test_saturation();
        int r[11];
        int k = 0;
        int nk;
        exp_t e, o;
        for (int it = 0; it < 18; it++) begin
            nk = (k < (1 << CB) - 1) ? k + 1 : k;
            for (int s = 0; s < 5; s++) begin
                case (s)
                    0: r = '{0,0,0,8,1,1,0, 0,0,0,k};
                    1: r = '{8,9,1,10,1,0,0, 0,0,1,k};
                    2: r = '{8,9,1,10,1,0,0, 0,0,0,nk};
                    3: r = '{0,0,0,0,0,0,0, 1,0,0,nk};
                    default: r = '{0,0,0,0,0,0,0, 0,0,0,nk};
                endcase
                drive(r); #2;
                e = sb.pop_front(); o = observe(); checks++;
                if (o !== e) begin
                    failures++;
                    $display("FAIL saturate iter %0d step %0d: got fa=%b fb=%b st=%b cnt=%0d want fa=%b fb=%b st=%b cnt=%0d",
                             it, s, o.fa, o.fb, o.st, o.cnt, e.fa, e.fb, e.st, e.cnt);
                end
            end
            k = nk;
        end
    endtask

    initial begin
        bus.ID_Rs = '0; bus.ID_Rt = '0; bus.ID_UsesRt = 1'b0; bus.ID_WriteReg = '0;
        bus.ID_RegWrite = 1'b0; bus.ID_MemRead = 1'b0; bus.Flush = 1'b0;
        test_reset();
        test_ex_fwd();
        test_wb_fwd();
        test_load_use();
        test_no_stall();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
